// File: rtl/rtdf_packet_builder_if.sv
// Stream-FIFO read port and Ethernet TX-FIFO write port seen by the packet builder.
// master is the builder side; slave is the FIFO side.
interface rtdf_packet_builder_if;
    logic [15:0] src_data;
    logic        src_empty;
    logic [8:0]  src_words_available;
    logic        src_rd_req;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_req;
    logic [15:0] tx_fifo_wr_data;

    modport master (
        input  src_data, src_empty, src_words_available, tx_fifo_full,
        output src_rd_req, tx_fifo_wr_req, tx_fifo_wr_data
    );

    modport slave (
        output src_data, src_empty, src_words_available, tx_fifo_full,
        input  src_rd_req, tx_fifo_wr_req, tx_fifo_wr_data
    );
endinterface

// File: rtl/rtdf_packet_builder.sv
// Builds fixed-payload Ethernet frames (length, MACs, EtherType, payload) one
// word per cycle from a show-ahead stream FIFO into the Ethernet TX FIFO.
module rtdf_packet_builder #(
    parameter int          PAYLOAD_WORDS = 256,
    parameter logic [47:0] DEST_MAC      = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0000_0000_0000,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
    input  logic                  clk_tx,
    input  logic                  reset,
    rtdf_packet_builder_if.master bus,
    output logic                  tx_start,
    output logic                  busy,
    output logic [8:0]            packet_count
);

    // Header states are consecutive so a header write simply steps to the next state.
    typedef enum logic [3:0] {
        ST_IDLE, ST_LENGTH, ST_DEST_0, ST_DEST_1, ST_DEST_2,
        ST_SOURCE_0, ST_SOURCE_1, ST_SOURCE_2, ST_ETHERTYPE, ST_DATA, ST_DONE
    } state_e;

    localparam logic [8:0]  START_LEVEL = 9'(PAYLOAD_WORDS);
    localparam logic [9:0]  LAST_WORD   = 10'(PAYLOAD_WORDS);
    localparam logic [15:0] LENGTH_WORD = {5'd0, 11'(14 + 2 * PAYLOAD_WORDS)};

    // The receive path expects the first wire byte in the low byte of each word.
    function automatic logic [15:0] wire_order(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    state_e      state_q, state_d;
    logic [9:0]  pay_cnt_q, pay_cnt_d;
    logic [8:0]  pkt_cnt_q, pkt_cnt_d;
    logic        tx_start_q, tx_start_d;
    logic        wr_req, rd_req;
    logic [15:0] wr_data;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d    = state_q;
        pay_cnt_d  = pay_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        tx_start_d = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.src_words_available >= START_LEVEL) state_d = ST_LENGTH;
            end
            ST_LENGTH, ST_DEST_0, ST_DEST_1, ST_DEST_2,
            ST_SOURCE_0, ST_SOURCE_1, ST_SOURCE_2, ST_ETHERTYPE: begin
                wr_req = !bus.tx_fifo_full;
                if (wr_req) begin
                    state_d   = state_e'(state_q + 4'd1);
                    pay_cnt_d = '0;
                end
            end
            ST_DATA: begin
                wr_req = !bus.tx_fifo_full && !bus.src_empty;
                rd_req = wr_req;
                if (wr_req) begin
                    pay_cnt_d = pay_cnt_q + 10'd1;
                    if (pay_cnt_d == LAST_WORD) begin
                        state_d    = ST_DONE;
                        tx_start_d = 1'b1;
                        pkt_cnt_d  = pkt_cnt_q + 9'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_LENGTH:    wr_data = LENGTH_WORD;
            ST_DEST_0:    wr_data = wire_order(DEST_MAC[47:32]);
            ST_DEST_1:    wr_data = wire_order(DEST_MAC[31:16]);
            ST_DEST_2:    wr_data = wire_order(DEST_MAC[15:0]);
            ST_SOURCE_0:  wr_data = wire_order(SRC_MAC[47:32]);
            ST_SOURCE_1:  wr_data = wire_order(SRC_MAC[31:16]);
            ST_SOURCE_2:  wr_data = wire_order(SRC_MAC[15:0]);
            ST_ETHERTYPE: wr_data = wire_order(ETHERTYPE);
            ST_DATA:      wr_data = bus.src_data;
            default:      wr_data = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_tx) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pay_cnt_q  <= '0;
            pkt_cnt_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pay_cnt_q  <= pay_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign bus.tx_fifo_wr_req  = wr_req;
    assign bus.tx_fifo_wr_data = wr_data;
    assign bus.src_rd_req      = rd_req;
    assign tx_start            = tx_start_q;
    assign busy                = (state_q != ST_IDLE);
    assign packet_count        = pkt_cnt_q;

endmodule

// File: doc/rtdf_packet_builder.md
# rtdf_packet_builder

Transmit-side counterpart of the RTDF packet processor. It drains 16-bit words from a show-ahead stream FIFO and builds fixed-payload Ethernet frames into the Ethernet TX FIFO, one word per cycle. Each frame is a length word, destination MAC, source MAC, EtherType and PAYLOAD_WORDS payload words. Byte order matches what the RTDF receive path expects, so frames built here parse correctly on the receive side. CRC is appended by the MAC and is never written by this block.

## Interface
- PAYLOAD_WORDS, 256: payload words per frame; legal range 23..511, so payload is 46..1022 bytes.
- DEST_MAC, 48'hFFFFFFFFFFFF: destination address; bits [47:40] are the first byte on the wire.
- SRC_MAC, 48'h000000000000: source address; same byte order as DEST_MAC.
- ETHERTYPE, 16'h88B5: EtherType written in every frame.
- clk_tx  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high.
- src_data  input  16  head word of the show-ahead stream FIFO; valid while src_empty is low.
- src_empty  input  1  stream FIFO empty.
- src_words_available  input  9  stream FIFO used-words count.
- src_rd_req  output  1  pops the stream FIFO head; combinational.
- tx_fifo_full  input  1  TX FIFO full.
- tx_fifo_wr_req  output  1  TX FIFO write strobe; combinational.
- tx_fifo_wr_data  output  16  TX FIFO write word; combinational mux of state and src_data.
- tx_start  output  1  registered one-cycle pulse when a frame's last word has been written.
- busy  output  1  high in every state except IDLE.
- packet_count  output  9  frames completed; wraps modulo 512.

## Operation
- States: IDLE, LENGTH, DEST_0, DEST_1, DEST_2, SOURCE_0, SOURCE_1, SOURCE_2, ETHERTYPE, DATA, DONE.
- IDLE -> LENGTH when src_words_available >= PAYLOAD_WORDS. This guarantees the whole payload is buffered before a frame starts.
- Emitting states are LENGTH through DATA.
  - tx_fifo_wr_req = emitting && !tx_fifo_full, except in DATA, where it also requires !src_empty.
  - The state advances only on a cycle where tx_fifo_wr_req is high; otherwise it holds.
- Word values (the first wire byte sits in the low byte):
  - LENGTH: {5'd0, 11-bit frame byte count}, where the count is 14 + 2*PAYLOAD_WORDS and excludes CRC.
  - DEST_0 = {DEST_MAC[39:32], DEST_MAC[47:40]}; DEST_1 = {[23:16], [31:24]}; DEST_2 = {[7:0], [15:8]}.
  - SOURCE_0..2 use the same pattern applied to SRC_MAC.
  - ETHERTYPE = {ETHERTYPE[7:0], ETHERTYPE[15:8]}.
  - DATA: tx_fifo_wr_data = src_data, and src_rd_req = tx_fifo_wr_req. Every payload write pops exactly one source word.
- Payload counter (10 bits):
  - Cleared on entry to DATA.
  - Increments on each payload write.
  - DATA -> DONE on the write that makes the count equal PAYLOAD_WORDS.
- DONE:
  - No writes are issued.
  - tx_start goes high for exactly one cycle, registered, during the DONE cycle.
  - packet_count increments by 1.
  - The next state is IDLE.
- src_rd_req is never high outside DATA. tx_fifo_wr_req is never high in IDLE or DONE.

## Timing
- Reset values: state IDLE, busy 0, tx_start 0, packet_count 0, payload counter 0. Combinational outputs (src_rd_req, tx_fifo_wr_req) are therefore 0.
- Reset asserted mid-frame: the block returns to IDLE on the next edge and writes nothing further. The TX FIFO shares the same reset, so a partial frame is discarded there.
- Unstalled frame length is 8 + PAYLOAD_WORDS write cycles.
  - The first write (LENGTH) occurs one cycle after the IDLE exit decision.
  - tx_start is high the cycle after the last payload write.
  - The next frame's LENGTH write is no earlier than 2 cycles after tx_start.
- tx_fifo_full high: the write and advance are suppressed that cycle, and the held word is presented unchanged once full deasserts. Nothing is lost or duplicated.
- src_empty high in DATA: the block stalls identically.
- src_empty and tx_fifo_full high together: the block stalls, with no write and no pop.
- src_words_available exactly equal to PAYLOAD_WORDS is sufficient to start.
- packet_count wraps from 511 to 0.

## Test plan
- Frame content check, with PAYLOAD_WORDS=23, SRC_MAC=48'h001122334455, ETHERTYPE=16'h88B5, DEST default, source preloaded with words 0x0000..0x0016:
  - Required writes: 16'h003C; 16'hFFFF ×3; 16'h1100, 16'h3322, 16'h5544; 16'hB588; then 0x0000..0x0016.
  - 31 writes in total, in consecutive cycles.
  - tx_start is one pulse; packet_count = 1.
- Start threshold: src_words_available = 22 -> busy stays 0 and no writes occur. Raise it to 23 -> LENGTH is written on the next cycle.
- TX backpressure: hold tx_fifo_full high for 5 cycles during SOURCE_1, and again for 3 cycles mid-payload -> the write sequence is identical to the first scenario, with no duplicate or missing word, and src_rd_req count = 23.
- Source underflow: force src_empty for 4 cycles during DATA -> no writes and no pops during those cycles; the payload resumes with the correct next word.
- Reset mid-frame: assert reset at payload word 10 -> the next cycle is IDLE with all outputs 0. A subsequent frame starts with the LENGTH word.
- Back-to-back frames: hold the source full for 3 frames -> 3 tx_start pulses, packet_count = 3, and the frames are separated by a gap of at least 2 cycles.
